dec_scan_pol: RTL and testbench
===============================

# dec_scan_pol

Parametrised, registered N-to-2^N decoder with output polarity control and an autonomous scan mode. In direct mode it decodes a select input into a one-hot (active-high) or one-cold (active-low) output vector. In scan mode it steps through every output in turn with a programmable dwell time and optional blanking. It replaces the fixed 2-to-4 combinational decoder wherever select lines drive multiplexed loads such as display digits, LED columns or bank enables.

## Interface
- `SEL_W`, 2: select width; output width `OUT_N = 2**SEL_W`.
- `PRESCALE_W`, 16: width of the dwell counter and the `period` input.
- `RESET_POL`, 1: polarity assumed during reset; sets the reset value of `D`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  1 = decoder active; 0 = all outputs inactive and scan state cleared.
- `pol`  in  1  1 = active-high one-hot; 0 = active-low one-cold.
- `mode`  in  1  0 = direct decode of `sel`; 1 = autonomous scan.
- `sel`  in  SEL_W  direct-mode select.
- `period`  in  PRESCALE_W  scan dwell; each channel is held for `period+1` cycles.
- `blank_en`  in  1  scan mode only: insert one all-inactive cycle between channels.
- `D`  out  OUT_N  registered decoder outputs; `D[i]` corresponds to index i.
- `cur_sel`  out  SEL_W  registered index currently driven (or about to be driven, during blank).
- `wrap`  out  1  one-cycle pulse when the scan index goes from OUT_N-1 to 0.

## Operation
- Inactive vector: `INACT = pol ? 0 : all ones`. Active channel k: `INACT` with bit k inverted.
- FSM states and behaviour:
  - OFF: entered when `en=0`. `D=INACT`, `cur_sel=0`, dwell counter=0, `wrap=0`.
  - DIRECT: entered when `en=1, mode=0`. `D` = decode of `sel` under `pol`; `cur_sel=sel`.
  - DWELL: entered when `en=1, mode=1`. `D` = channel `cur_sel`. The counter increments each cycle. When `counter >= period`, the counter clears and the index advances (wraps at OUT_N-1 to 0).
    - `blank_en=1`: go to BLANK after advancing.
    - `blank_en=0`: stay in DWELL.
  - BLANK: one cycle with `D=INACT` and `cur_sel` already at the next index, then return to DWELL.
- Entering scan from OFF or DIRECT always starts at index 0 with counter=0.
- Leaving scan (mode to 0) goes to DIRECT at the next edge. Scan index and counter are discarded.
- `period` is compared live. Lowering it below the current count advances the index at the next edge.
- A `pol` change flips output polarity only. The index, counter and state are unaffected.
- `en` has priority over `mode`.
- `wrap` asserts in the same cycle that `cur_sel` becomes 0 through an advance, never on scan entry.

## Timing
- All outputs are registered. A change on `en`, `mode`, `sel` or `pol` appears on `D` one cycle later.
- Scan with `blank_en=0`: each channel lasts `period+1` cycles, so a full frame is `OUT_N*(period+1)`.
- Scan with `blank_en=1`: each channel lasts `period+1` cycles plus one blank cycle.
- Reset (asynchronous, immediate; also mid-scan):
  - `D = RESET_POL ? 0 : all ones`, `cur_sel=0`, `wrap=0`.
  - State OFF, counter 0.
- First edge after reset release: the state follows `en`/`mode`.

## Configuration
- `DEC_LEGACY_SWAP_EN` defined: output bits 0 and 1 are swapped on `D`. Index 0 asserts `D[1]` and index 1 asserts `D[0]`, matching legacy board column order. `cur_sel`, scan order and `wrap` are unchanged.
- Not defined: `D[i]` is asserted for index i.

## Structure
- Shared package `dec_pkg`: FSM state encodings (OFF, DIRECT, DWELL, BLANK) and a polarity-apply constant function.
- One sub-module, `dec_onehot`: purely combinational SEL_W-to-OUT_N one-hot decode, including the optional legacy swap. Polarity, registers, FSM and counter stay in `dec_scan_pol`.

## Test plan
All scenarios use SEL_W=2.
- Reset, RESET_POL=1: `rst_n=0` gives `D=4'b0000`, `cur_sel=0`, `wrap=0` immediately. Asserting reset mid-scan clears asynchronously, without waiting for a clock edge.
- Direct decode: `en=1, mode=0, pol=1, sel=2` gives `D=4'b0100` one cycle later. Then `pol=0` gives `D=4'b1011` the next cycle.
- Scan, `period=3, blank_en=0, pol=1`: `D` is 0001 for 4 cycles, then 0010, 0100 and 1000 for 4 cycles each, then 0001 again. `wrap=1` only on the cycle `D` returns to 0001.
- Scan, `period=0, blank_en=1`: `D` = 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001. During each blank, `cur_sel` already shows the next index.
- Disable mid-scan: `en` drops while `cur_sel=2`, giving `D=0000` and `cur_sel=0` next cycle. Re-enabling restarts at 0001 with no `wrap`.
- `DEC_LEGACY_SWAP_EN` defined, direct, `pol=1`: `sel=0` gives `D=4'b0010`, `sel=1` gives `4'b0001`, `sel=3` gives `4'b1000`.

Source files
------------

// File: rtl/dec_pkg.sv
// dec_pkg: shared FSM state encoding and polarity helper for dec_scan_pol
package dec_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DIRECT,
        ST_DWELL,
        ST_BLANK
    } state_t;

    function automatic logic apply_pol(input logic act, input logic pol);
        return pol ? act : ~act;
    endfunction

endpackage

// File: rtl/dec_scan_pol_if.sv
// dec_scan_pol_if: control inputs and registered outputs of the scanning decoder
interface dec_scan_pol_if #(
    parameter int SEL_W      = 2,
    parameter int PRESCALE_W = 16
);
    localparam int OUT_N = 2 ** SEL_W;

    logic                  en;
    logic                  pol;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [PRESCALE_W-1:0] period;
    logic                  blank_en;
    logic [OUT_N-1:0]      D;
    logic [SEL_W-1:0]      cur_sel;
    logic                  wrap;

    modport master (
        output en, pol, mode, sel, period, blank_en,
        input  D, cur_sel, wrap
    );

    modport slave (
        input  en, pol, mode, sel, period, blank_en,
        output D, cur_sel, wrap
    );

endinterface

// File: rtl/dec_onehot.sv
// dec_onehot: combinational SEL_W-to-2**SEL_W one-hot decode; DEC_LEGACY_SWAP_EN swaps bits 0 and 1
module dec_onehot #(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   onehot
);

    // Legacy boards wire columns 0 and 1 crossed, so their bits are exchanged
    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
`ifdef DEC_LEGACY_SWAP_EN
        onehot = {onehot[2**SEL_W-1:2], onehot[0], onehot[1]};
`endif
    end

endmodule

// File: rtl/dec_scan_pol.sv
// dec_scan_pol: registered decoder with polarity control and autonomous scan (optional DEC_LEGACY_SWAP_EN)
module dec_scan_pol
    import dec_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int PRESCALE_W = 16,
    parameter int RESET_POL  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    dec_scan_pol_if.slave  bus
);

    localparam int OUT_N = 2 ** SEL_W;

    state_t                state, state_nx;
    logic [PRESCALE_W-1:0] cnt, cnt_nx;
    logic [SEL_W-1:0]      idx_nx;
    logic                  wrap_nx;
    logic                  show;
    logic [OUT_N-1:0]      oh;
    logic [OUT_N-1:0]      d_nx;

    dec_onehot #(.SEL_W(SEL_W)) u_onehot (
        .sel    (idx_nx),
        .onehot (oh)
    );

    // Next state, next index and next output vector; en outranks mode
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = bus.cur_sel;
        wrap_nx  = 1'b0;
        show     = 1'b1;
        if (!bus.en) begin
            state_nx = ST_OFF;
            cnt_nx   = '0;
            idx_nx   = '0;
            show     = 1'b0;
        end else if (!bus.mode) begin
            state_nx = ST_DIRECT;
            cnt_nx   = '0;
            idx_nx   = bus.sel;
        end else if (state == ST_OFF || state == ST_DIRECT) begin
            state_nx = ST_DWELL;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else if (state == ST_BLANK) begin
            state_nx = ST_DWELL;
        end else if (cnt >= bus.period) begin
            cnt_nx   = '0;
            idx_nx   = bus.cur_sel + 1'b1;
            wrap_nx  = &bus.cur_sel;
            state_nx = bus.blank_en ? ST_BLANK : ST_DWELL;
            show     = !bus.blank_en;
        end else begin
            cnt_nx = cnt + 1'b1;
        end
        for (int i = 0; i < OUT_N; i++)
            d_nx[i] = apply_pol(show & oh[i], bus.pol);
    end

    // State, dwell counter and all outputs are registered together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_OFF;
            cnt         <= '0;
            bus.D       <= (RESET_POL != 0) ? '0 : '1;
            bus.cur_sel <= '0;
            bus.wrap    <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            bus.D       <= d_nx;
            bus.cur_sel <= idx_nx;
            bus.wrap    <= wrap_nx;
        end
    end

endmodule

// File: tb/tb_dec_scan_pol.sv
// tb_dec_scan_pol: directed and randomized self-checking bench for dec_scan_pol
module tb_dec_scan_pol;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    // Reference model: scan position and whether a channel is shown
    bit   m_scan, m_blank, m_on, m_wrap;
    int   m_idx, m_cnt;

    always #5 clk = ~clk;

    dec_scan_pol_if #(.SEL_W(2), .PRESCALE_W(16)) bus ();

    dec_scan_pol #(.SEL_W(2), .PRESCALE_W(16), .RESET_POL(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_scan = 0; m_blank = 0; m_on = 0; m_wrap = 0; m_idx = 0; m_cnt = 0;
    endtask

    // One clock of the behavioural rules, evaluated with the inputs present at the edge
    task automatic model_tick();
        m_wrap = 0;
        if (!bus.en) begin
            model_reset();
        end else if (!bus.mode) begin
            m_scan = 0; m_blank = 0; m_on = 1; m_idx = int'(bus.sel); m_cnt = 0;
        end else if (!m_scan) begin
            m_scan = 1; m_blank = 0; m_on = 1; m_idx = 0; m_cnt = 0;
        end else if (m_blank) begin
            m_blank = 0; m_on = 1;
        end else if (m_cnt >= int'(bus.period)) begin
            m_cnt = 0;
            m_wrap = (m_idx == 3);
            m_idx = (m_idx + 1) % 4;
            m_blank = bus.blank_en;
            m_on = !bus.blank_en;
        end else begin
            m_cnt++;
        end
    endtask

    function automatic logic [3:0] exp_d();
        logic [3:0] v;
        v = m_on ? 4'(1 << m_idx) : 4'b0000;
`ifdef DEC_LEGACY_SWAP_EN
        v = {v[3:2], v[0], v[1]};
`endif
        return bus.pol ? v : ~v;
    endfunction

    task automatic step(input string tag);
        @(posedge clk);
        model_tick();
        #1;
        chk({tag, "_D"}, 32'(bus.D), 32'(exp_d()));
        chk({tag, "_cur_sel"}, 32'(bus.cur_sel), 32'(m_idx));
        chk({tag, "_wrap"}, 32'(bus.wrap), 32'(m_wrap));
    endtask

    initial begin
        logic [3:0] blank_d [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                    4'b0000, 4'b1000, 4'b0000, 4'b0001};
        int         blank_s [9] = '{0, 1, 1, 2, 2, 3, 3, 0, 0};
        bit         found;

        bus.en = 0; bus.pol = 1; bus.mode = 0; bus.sel = 0; bus.period = 0; bus.blank_en = 0;
        model_reset();
        #3;
        chk("reset_D", 32'(bus.D), 32'h0);
        chk("reset_cur_sel", 32'(bus.cur_sel), 32'h0);
        chk("reset_wrap", 32'(bus.wrap), 32'h0);
        @(negedge clk);
        rst_n = 1;

        bus.en = 1; bus.mode = 0; bus.pol = 1; bus.sel = 2;
        step("direct_hi");
        chk("direct_hi_lit", 32'(bus.D), 32'h4);
        bus.pol = 0;
        step("direct_lo");
        chk("direct_lo_lit", 32'(bus.D), 32'hB);

        bus.pol = 1; bus.period = 3; bus.blank_en = 0; bus.mode = 1;
        for (int i = 0; i < 17; i++) begin
            step("scan_p3");
            chk("scan_p3_lit", 32'(bus.D), 32'(1 << ((i / 4) % 4)));
            chk("scan_p3_wrap_lit", 32'(bus.wrap), 32'(i == 16));
        end

        bus.mode = 0;
        step("to_direct");
        bus.mode = 1; bus.period = 0; bus.blank_en = 1;
        for (int i = 0; i < 9; i++) begin
            step("scan_blank");
            chk("scan_blank_lit", 32'(bus.D), 32'(blank_d[i]));
            chk("scan_blank_sel_lit", 32'(bus.cur_sel), 32'(blank_s[i]));
        end

        bus.blank_en = 0;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            step("seek_sel2");
            found = (bus.cur_sel == 2'd2);
        end
        chk("reach_sel2", 32'(found), 32'h1);
        bus.en = 0;
        step("disable");
        chk("disable_D_lit", 32'(bus.D), 32'h0);
        chk("disable_sel_lit", 32'(bus.cur_sel), 32'h0);
        bus.en = 1;
        step("reenable");
        chk("reenable_D_lit", 32'(bus.D), 32'h1);
        chk("reenable_wrap_lit", 32'(bus.wrap), 32'h0);

        step("pre_rst_a");
        step("pre_rst_b");
        #3;
        rst_n = 0;
        #1;
        chk("midscan_rst_D", 32'(bus.D), 32'h0);
        chk("midscan_rst_sel", 32'(bus.cur_sel), 32'h0);
        chk("midscan_rst_wrap", 32'(bus.wrap), 32'h0);
        model_reset();
        #2;
        rst_n = 1;
        step("post_rst");

`ifdef DEC_LEGACY_SWAP_EN
        bus.mode = 0; bus.pol = 1;
        bus.sel = 0; step("swap0"); chk("swap0_lit", 32'(bus.D), 32'h2);
        bus.sel = 1; step("swap1"); chk("swap1_lit", 32'(bus.D), 32'h1);
        bus.sel = 3; step("swap3"); chk("swap3_lit", 32'(bus.D), 32'h8);
`endif

        for (int i = 0; i < 400; i++) begin
            bus.en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 9) == 0) bus.mode = ~bus.mode;
            if ($urandom_range(0, 9) == 0) bus.pol = ~bus.pol;
            if ($urandom_range(0, 9) == 0) bus.blank_en = ~bus.blank_en;
            if ($urandom_range(0, 7) == 0) bus.period = 16'($urandom_range(0, 4));
            bus.sel = 2'($urandom_range(0, 3));
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
